dmem_request_ctrl: RTL and testbench
====================================

DMEM_REQUEST_CTRL -- requirements
Module: dmem_request_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13: byte-address width on both sides; addresses wrap modulo 2^ADDR_W.
REQ-002 Parameter BIG_ENDIAN, default 0: 0 places the byte at addr+0 in rdata[7:0]; 1 places it in rdata[31:24].
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_write  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  ADDR_W  byte address of the word.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  one-cycle pulse: request complete.
REQ-011 resp_rdata  output  32  assembled load data.
REQ-012 mem_address  output  ADDR_W  address to the banked DMEM.
REQ-013 mem_data_in  output  32  write data to the DMEM.
REQ-014 mem_read_write  output  1  1 = write strobe, 0 = read.
REQ-015 mem_data_out  input  8  DMEM read byte for the address presented on the previous cycle.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, WR, RD, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE with reset low; acceptance = req_valid & req_ready at a posedge.
REQ-018 On acceptance, req_write, req_addr and req_wdata SHALL be latched; later request-input changes are ignored until the next acceptance.
REQ-019 IDLE -> WR on an accepted store; IDLE -> RD on an accepted load; otherwise stay in IDLE.
REQ-020 WR SHALL last exactly one cycle, driving mem_address = latched addr, mem_data_in = latched wdata and mem_read_write = 1; then -> RESP.
REQ-021 RD SHALL last exactly 5 cycles, counted by a 3-bit byte counter k = 0..4 that clears on entry.
REQ-022 In RD, cycles k = 0..3 SHALL drive mem_address = (addr + k) mod 2^ADDR_W with mem_read_write = 0.
REQ-023 In RD, cycles k = 1..4 SHALL capture mem_data_out as byte k-1 into the assembly register, placed per BIG_ENDIAN.
REQ-024 After k = 4, the FSM SHALL go RD -> RESP.
REQ-025 RESP SHALL last one cycle with resp_valid = 1, then -> IDLE, so back-to-back requests are spaced by the RESP cycle.
REQ-026 resp_rdata SHALL update only when a load reaches RESP, and SHALL hold its value across stores and idle cycles.
REQ-027 Latency: store resp_valid in the 2nd cycle after the acceptance edge; load resp_valid in the 6th cycle after it.
REQ-028 Unaligned addresses SHALL be legal; byte addresses crossing 2^ADDR_W-1 SHALL wrap to 0 (this may cross DMEM bank boundaries).
REQ-029 Outside WR and RD, mem_read_write SHALL be 0, mem_address 0 and mem_data_in 0.
REQ-030 mem_read_write SHALL be gated by !reset, so no write is issued in any cycle where reset is high.

Reset
REQ-031 While reset is high at a posedge, the next state SHALL be IDLE, k = 0, resp_valid = 0, resp_rdata = 0 and the latched request cleared.
REQ-032 Reset during WR or RD SHALL abort the operation with no resp_valid pulse; a partially assembled load SHALL be discarded.
REQ-033 A request presented while reset is high SHALL NOT be accepted.

Verification
REQ-034 Store 0xDEADBEEF at 0x0040 -> one cycle with mem_read_write = 1, mem_address = 0x0040, mem_data_in = 0xDEADBEEF; resp_valid 2 cycles after acceptance.
REQ-035 Load from 0x0040 with a byte-memory model holding EF,BE,AD,DE at 0x40..0x43, BIG_ENDIAN = 0 -> addresses 0x40..0x43 issued on consecutive cycles; resp_rdata = 0xDEADBEEF with resp_valid 6 cycles after acceptance.
REQ-036 Load at 0x1FFE -> mem_address sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001; bytes assembled in that order.
REQ-037 Reset asserted on RD cycle k = 2 -> no resp_valid; IDLE next cycle; req_ready = 1 after reset deasserts; resp_rdata = 0.
REQ-038 req_valid held high with alternating store and load requests -> req_ready low outside IDLE; each request accepted exactly once; inputs changed mid-operation have no effect.
REQ-039 Same load as REQ-035 with BIG_ENDIAN = 1 -> resp_rdata = 0xEFBEADDE.

Source files
------------

// File: rtl/dmem_request_ctrl.sv
// Purpose : word-level CPU load/store front end for a byte-wide banked DMEM;
//           stores are one word-wide write cycle, loads are four byte reads
//           assembled into a 32-bit word.
// Latency : store resp_valid 2 cycles after acceptance, load resp_valid 6 cycles after.
// Backpressure: req_ready is high only in IDLE (and not in reset); one request in flight.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/req_ready        CPU request handshake
//   req_write/addr/wdata       request payload (latched on acceptance)
//   resp_valid/resp_rdata      one-cycle completion pulse and load data
//   mem_address/data_in/rw     DMEM command (rw = 1 write strobe)
//   mem_data_out               DMEM read byte for the previous cycle's address
module dmem_request_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_read_write,
    input  logic [7:0]        mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_k;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic              r_resp_vld;
    logic [31:0]       r_resp_rdata;

    logic              w_accept;
    logic [1:0]        w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_asm_next;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic              w_mem_rw;

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    // On RD cycle k the incoming byte is byte k-1 of the word (read latency 1).
    // For k = 4 the low bits wrap to 0, so k-1 gives lane 3 as required.
    assign w_idx  = r_k[1:0] - 2'd1;
    assign w_lane = (BIG_ENDIAN != 0) ? ~w_idx : w_idx;

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{w_lane, 3'b000} +: 8] = mem_data_out;
    end

    // DMEM command is a pure decode of registered state; zero outside WR/RD.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_rw    = 1'b0;
        case (r_state)
            S_WR: begin
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
                w_mem_rw    = r_write;
            end
            S_RD: begin
                // Address arithmetic wraps naturally at ADDR_W bits.
                if (r_k <= 3'd3) begin
                    w_mem_addr = r_addr + ADDR_W'(r_k);
                end
            end
            default: ;
        endcase
    end

    assign mem_address    = w_mem_addr;
    assign mem_data_in    = w_mem_wdata;
    // The write strobe is suppressed combinationally in any reset cycle.
    assign mem_read_write = w_mem_rw && !reset;
    assign resp_valid     = r_resp_vld;
    assign resp_rdata     = r_resp_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_k          <= 3'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_asm        <= '0;
            r_resp_vld   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_k     <= 3'd0;
                        r_asm   <= '0;
                        r_state <= req_write ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    r_resp_vld <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RD: begin
                    if (r_k != 3'd0) begin
                        r_asm <= w_asm_next;
                    end
                    if (r_k == 3'd4) begin
                        // Last byte goes straight into the response word so the
                        // result is visible in the RESP cycle.
                        if (!r_write) begin
                            r_resp_rdata <= w_asm_next;
                        end
                        r_resp_vld <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_request_ctrl.sv
module tb_dmem_request_ctrl;

    localparam int ADDR_W = 13;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [7:0]        mem_data_out;

    logic              req_ready,   be_req_ready;
    logic              resp_valid,  be_resp_valid;
    logic [31:0]       resp_rdata,  be_resp_rdata;
    logic [ADDR_W-1:0] mem_address, be_mem_address;
    logic [31:0]       mem_data_in, be_mem_data_in;
    logic              mem_read_write, be_mem_read_write;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_rsp = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    dmem_request_ctrl #(.ADDR_W(ADDR_W), .BIG_ENDIAN(0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
    );

    // Big-endian instance sees identical stimulus and the same read bytes.
    dmem_request_ctrl #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(be_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(be_resp_valid), .resp_rdata(be_resp_rdata),
        .mem_address(be_mem_address), .mem_data_in(be_mem_data_in),
        .mem_read_write(be_mem_read_write), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory with one cycle read latency.
    always @(posedge clk) begin
        mem_data_out <= mem[mem_address];
        if (mem_read_write) n_wr <= n_wr + 1;
        if (resp_valid)     n_rsp <= n_rsp + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[13'h0040] = 8'hEF; mem[13'h0041] = 8'hBE;
        mem[13'h0042] = 8'hAD; mem[13'h0043] = 8'hDE;
        mem[13'h1FFE] = 8'h11; mem[13'h1FFF] = 8'h22;
        mem[13'h0000] = 8'h33; mem[13'h0001] = 8'h44;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0;
        tick(); tick();

        // ---- reset state
        check("rst_ready",  {31'd0, req_ready}, 32'd0);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata",  resp_rdata, 32'd0);
        check("rst_rw",     {31'd0, mem_read_write}, 32'd0);
        reset = 1'b0; #1;
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        check("idle_addr",  {19'd0, mem_address}, 32'd0);

        // ---- store 0xDEADBEEF at 0x0040
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h0040; req_wdata = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0; req_addr = 13'h0123; req_wdata = 32'h0;
        check("st_rw",    {31'd0, mem_read_write}, 32'd1);
        check("st_addr",  {19'd0, mem_address}, 32'h40);
        check("st_data",  mem_data_in, 32'hDEADBEEF);
        check("st_ready", {31'd0, req_ready}, 32'd0);
        check("st_rv1",   {31'd0, resp_valid}, 32'd0);
        tick();
        check("st_rv2",   {31'd0, resp_valid}, 32'd1);
        check("st_rw_off",{31'd0, mem_read_write}, 32'd0);
        check("st_data0", mem_data_in, 32'd0);
        check("st_hold",  resp_rdata, 32'd0);
        tick();
        check("st_rv3",   {31'd0, resp_valid}, 32'd0);

        // ---- load 0x0040, LE and BE instances
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h0040;
        tick();
        req_valid = 1'b0; req_addr = 13'h0999;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("ld_addr%0d", c), {19'd0, mem_address},
                  (c <= 4) ? 32'h40 + 32'(c - 1) : 32'd0);
            check($sformatf("ld_rv%0d", c), {31'd0, resp_valid}, 32'd0);
            check($sformatf("ld_rw%0d", c), {31'd0, mem_read_write}, 32'd0);
            tick();
        end
        check("ld_rv6",    {31'd0, resp_valid}, 32'd1);
        check("ld_le",     resp_rdata, 32'hDEADBEEF);
        check("ld_be",     be_resp_rdata, 32'hEFBEADDE);
        tick();
        check("ld_rv7",    {31'd0, resp_valid}, 32'd0);
        check("ld_hold",   resp_rdata, 32'hDEADBEEF);

        // ---- wrapping load at 0x1FFE
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h1FFE;
        tick();
        req_valid = 1'b0;
        check("wr_a0", {19'd0, mem_address}, 32'h1FFE); tick();
        check("wr_a1", {19'd0, mem_address}, 32'h1FFF); tick();
        check("wr_a2", {19'd0, mem_address}, 32'h0000); tick();
        check("wr_a3", {19'd0, mem_address}, 32'h0001); tick();
        check("wr_rv5", {31'd0, resp_valid}, 32'd0);    tick();
        check("wr_rv6", {31'd0, resp_valid}, 32'd1);
        check("wr_le",  resp_rdata, 32'h44332211);
        check("wr_be",  be_resp_rdata, 32'h11223344);
        tick();

        // ---- reset on RD cycle k = 2
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h0040;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("ab_k2addr", {19'd0, mem_address}, 32'h42);
        reset = 1'b1;
        // a request presented during reset must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h0055; req_wdata = 32'hAAAA5555;
        tick();
        check("ab_rv",    {31'd0, resp_valid}, 32'd0);
        check("ab_rdata", resp_rdata, 32'd0);
        check("ab_ready", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b0; req_valid = 1'b0; #1;
        check("ab_ready2", {31'd0, req_ready}, 32'd1);
        check("ab_rw",     {31'd0, mem_read_write}, 32'd0);
        check("ab_rv2",    {31'd0, resp_valid}, 32'd0);
        check("ab_addr",   {19'd0, mem_address}, 32'd0);

        // ---- reset during WR suppresses the strobe and the response
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rw_pre",  {31'd0, mem_read_write}, 32'd1);
        reset = 1'b1; #1;
        check("rw_gate", {31'd0, mem_read_write}, 32'd0);
        tick();
        reset = 1'b0; #1;
        check("rw_rv",    {31'd0, resp_valid}, 32'd0);
        check("rw_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("rw_rv2",   {31'd0, resp_valid}, 32'd0);

        // ---- back-to-back with req_valid held high
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h0100; req_wdata = 32'h12345678;
        tick();
        req_write = 1'b0; req_addr = 13'h01FF; req_wdata = 32'h0;
        check("bb_s1_ready", {31'd0, req_ready}, 32'd0);
        check("bb_s1_rw",    {31'd0, mem_read_write}, 32'd1);
        check("bb_s1_addr",  {19'd0, mem_address}, 32'h100);
        check("bb_s1_data",  mem_data_in, 32'h12345678);
        tick();
        check("bb_s1_rv",    {31'd0, resp_valid}, 32'd1);
        check("bb_s1_ready2",{31'd0, req_ready}, 32'd0);
        check("bb_s1_hold",  resp_rdata, 32'd0);
        req_write = 1'b0; req_addr = 13'h0040;
        tick();
        check("bb_idle1",    {31'd0, req_ready}, 32'd1);
        check("bb_idle1_rv", {31'd0, resp_valid}, 32'd0);
        tick();
        req_write = 1'b1; req_addr = 13'h0007; req_wdata = 32'hFFFFFFFF;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("bb_ld_ready%0d", c), {31'd0, req_ready}, 32'd0);
            check($sformatf("bb_ld_rw%0d", c), {31'd0, mem_read_write}, 32'd0);
            check($sformatf("bb_ld_addr%0d", c), {19'd0, mem_address},
                  (c <= 4) ? 32'h40 + 32'(c - 1) : 32'd0);
            tick();
        end
        check("bb_ld_rv",    {31'd0, resp_valid}, 32'd1);
        check("bb_ld_data",  resp_rdata, 32'hDEADBEEF);
        req_write = 1'b1; req_addr = 13'h0101; req_wdata = 32'hCAFEF00D;
        tick();
        check("bb_idle2",    {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("bb_s2_addr",  {19'd0, mem_address}, 32'h101);
        check("bb_s2_data",  mem_data_in, 32'hCAFEF00D);
        tick();
        check("bb_s2_rv",    {31'd0, resp_valid}, 32'd1);
        check("bb_s2_hold",  resp_rdata, 32'hDEADBEEF);
        tick();
        check("bb_end_rv",   {31'd0, resp_valid}, 32'd0);
        tick(); tick();

        // each request handled exactly once over the whole run
        check("total_writes", 32'(n_wr), 32'd3);
        check("total_resps",  32'(n_rsp), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
